// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_e        : arbiter FSM states (IDLE/READ/WRITE/ACK)
//   CNT_W          : width of the access-latency down-counter
//   READ_LAT_DEF   : default edges from mem_read assertion to data capture
//   WRITE_LAT_DEF  : default number of cycles mem_write is held high
package mem_arb_pkg;

  localparam int unsigned CNT_W         = 4;
  localparam int unsigned READ_LAT_DEF  = 3;
  localparam int unsigned WRITE_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational two-way round-robin picker.
//   req       in  [1:0] request per port (bit 0 = port 0)
//   last      in        port granted most recently
//   gnt_valid out       at least one request present
//   gnt_id    out       port to grant; on a tie the port that is not 'last'
module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between two requesters with
// round-robin arbitration. All outputs are registered.
//   clk, reset              clock (rising edge), async active-high reset
//   pN_req/we/addr/wdata    port N request, held stable until pN_ack
//   pN_ack                  port N completion, one-cycle pulse
//   rdata                   captured read data, valid with the read's ack
//   owner                   port currently or last granted
//   busy                    high in READ, WRITE and ACK
//   mem_addr/mem_write_data registered memory address / write data
//   mem_read/mem_write      registered memory strobes
//   mem_read_data           memory read data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned READ_LAT  = READ_LAT_DEF,
  parameter int unsigned WRITE_LAT = WRITE_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              owner,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WRITE_LAT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                busy_q, busy_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                p0_ack_q, p0_ack_d;
  logic                p1_ack_q, p1_ack_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                gnt_valid;
  logic                gnt_id;
  logic                gnt_we;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_wdata;

  mem_arb_rr u_rr (
    .req       ({p1_req, p0_req}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    gnt_we    = gnt_id ? p1_we    : p0_we;
    gnt_addr  = gnt_id ? p1_addr  : p0_addr;
    gnt_wdata = gnt_id ? p1_wdata : p0_wdata;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = gnt_we ? WRITE : READ;
        end
      end
      READ:    if (cnt_q == '0) state_d = ACK;
      WRITE:   if (cnt_q == '0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d    = gnt_id;
          last_d     = gnt_id;
          mem_addr_d = gnt_addr;
          if (gnt_we) begin
            mem_write_d = 1'b1;
            wdata_d     = gnt_wdata;
            cnt_d       = WR_CNT_INIT;
          end else begin
            mem_read_d  = 1'b1;
            cnt_d       = RD_CNT_INIT;
          end
        end
      end
      READ: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rdata_d    = mem_read_data;
          mem_read_d = 1'b0;
          // owner_q still names the port granted for this access
          p0_ack_d   = ~owner_q;
          p1_ack_d   = owner_q;
        end
      end
      WRITE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_write_d = 1'b0;
          p0_ack_d    = ~owner_q;
          p1_ack_d    = owner_q;
        end
      end
      default: ;
    endcase
    // Registered busy follows the state being entered
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign p0_ack         = p0_ack_q;
  assign p1_ack         = p1_ack_q;
  assign rdata          = rdata_q;
  assign owner          = owner_q;
  assign busy           = busy_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = wdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three instances (READ_LAT/WRITE_LAT
// of 3/1, 1/4 and 15/4), each with its own memory model and monitor.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst            [3];
  logic        p0_req         [3];
  logic        p0_we          [3];
  logic [31:0] p0_addr        [3];
  logic [31:0] p0_wdata       [3];
  logic        p0_ack         [3];
  logic        p1_req         [3];
  logic        p1_we          [3];
  logic [31:0] p1_addr        [3];
  logic [31:0] p1_wdata       [3];
  logic        p1_ack         [3];
  logic [31:0] rdata          [3];
  logic        owner          [3];
  logic        busy           [3];
  logic [31:0] mem_addr       [3];
  logic [31:0] mem_write_data [3];
  logic        mem_read       [3];
  logic        mem_write      [3];
  logic [31:0] mem_read_data  [3];

  int checks   = 0;
  int failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input int unsigned k, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL dut%0d %s: got 0x%08h expected 0x%08h", k, name, act, exp);
    end
  endtask

  // Memory contents used by the model
  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h10) return 32'hCAFE_BABE;
    return {16'hD00D, a[15:0]};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_inst
    localparam int unsigned RL = (k == 0) ? 3 : ((k == 1) ? 1 : 15);
    localparam int unsigned WL = (k == 0) ? 1 : 4;

    exp_t        sb[$];
    int unsigned rd_cnt = 0;

    // Data is only correct on the exact capture edge; otherwise a marker
    always @(posedge clk) rd_cnt <= mem_read[k] ? rd_cnt + 1 : 0;
    assign mem_read_data[k] = (mem_read[k] && rd_cnt == RL - 1) ?
                              memval(mem_addr[k]) : (32'hBAD0_0000 | rd_cnt);

    mem_port_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .READ_LAT (RL),
      .WRITE_LAT(WL)
    ) u_dut (
      .clk           (clk),
      .reset         (rst[k]),
      .p0_req        (p0_req[k]),
      .p0_we         (p0_we[k]),
      .p0_addr       (p0_addr[k]),
      .p0_wdata      (p0_wdata[k]),
      .p0_ack        (p0_ack[k]),
      .p1_req        (p1_req[k]),
      .p1_we         (p1_we[k]),
      .p1_addr       (p1_addr[k]),
      .p1_wdata      (p1_wdata[k]),
      .p1_ack        (p1_ack[k]),
      .rdata         (rdata[k]),
      .owner         (owner[k]),
      .busy          (busy[k]),
      .mem_addr      (mem_addr[k]),
      .mem_write_data(mem_write_data[k]),
      .mem_read      (mem_read[k]),
      .mem_write     (mem_write[k]),
      .mem_read_data (mem_read_data[k])
    );

    // Monitor: tracks each strobe and checks it when the ack appears
    logic        active, done, was_wr, prev_ack;
    logic [31:0] s_addr, s_wd;
    int unsigned width;
    exp_t        e;

    initial begin
      active = 1'b0; done = 1'b0; was_wr = 1'b0; prev_ack = 1'b0;
      s_addr = '0; s_wd = '0; width = 0;
      forever begin
        @(negedge clk);
        if (rst[k]) begin
          active = 1'b0; done = 1'b0; prev_ack = 1'b0;
        end else begin
          chk(k, "rd_wr_overlap", {31'd0, mem_read[k] & mem_write[k]}, 32'd0);
          chk(k, "ack_overlap", {31'd0, p0_ack[k] & p1_ack[k]}, 32'd0);
          if (mem_read[k] || mem_write[k]) begin
            if (!active) begin
              active = 1'b1; width = 1; done = 1'b0;
              s_addr = mem_addr[k]; s_wd = mem_write_data[k]; was_wr = mem_write[k];
            end else begin
              width++;
            end
          end else if (active) begin
            active = 1'b0; done = 1'b1;
          end
          if (prev_ack) begin
            chk(k, "idle_after_ack", {31'd0, busy[k]}, 32'd0);
            chk(k, "ack_pulse_width", {31'd0, p0_ack[k] | p1_ack[k]}, 32'd0);
          end
          if (p0_ack[k] || p1_ack[k]) begin
            if (sb.size() == 0) begin
              chk(k, "unexpected_ack", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              chk(k, "ack_port", {31'd0, p1_ack[k]}, {31'd0, e.port});
              chk(k, "owner", {31'd0, owner[k]}, {31'd0, e.port});
              chk(k, "busy_in_ack", {31'd0, busy[k]}, 32'd1);
              chk(k, "strobe_done", {31'd0, done}, 32'd1);
              chk(k, "access_kind", {31'd0, was_wr}, {31'd0, e.we});
              chk(k, "mem_addr", s_addr, e.addr);
              chk(k, "strobe_width", width, e.we ? WL : RL);
              if (e.we) chk(k, "mem_write_data", s_wd, e.wdata);
              chk(k, "rdata", rdata[k], e.rdata);
            end
            done = 1'b0;
          end
          prev_ack = p0_ack[k] | p1_ack[k];
        end
      end
    end
  end

  function automatic exp_t mk(input logic p, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd);
    exp_t x;
    x.port = p; x.we = w; x.addr = a; x.wdata = wd; x.rdata = rd;
    return x;
  endfunction

  task automatic push(input int unsigned k, input exp_t x);
    case (k)
      0:       g_inst[0].sb.push_back(x);
      1:       g_inst[1].sb.push_back(x);
      default: g_inst[2].sb.push_back(x);
    endcase
  endtask

  task automatic drive(input int unsigned k, input logic port, input logic req,
                       input logic we, input logic [31:0] a, input logic [31:0] wd);
    if (port) begin
      p1_req[k] = req; p1_we[k] = we; p1_addr[k] = a; p1_wdata[k] = wd;
    end else begin
      p0_req[k] = req; p0_we[k] = we; p0_addr[k] = a; p0_wdata[k] = wd;
    end
  endtask

  task automatic wait_ack(input int unsigned k, input logic port);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = port ? p1_ack[k] : p0_ack[k];
    end
    chk(k, "ack_timeout", {31'd0, got}, 32'd1);
    if (port) p1_req[k] = 1'b0; else p0_req[k] = 1'b0;
  endtask

  task automatic do_req(input int unsigned k, input logic port, input logic we,
                        input logic [31:0] a, input logic [31:0] wd);
    drive(k, port, 1'b1, we, a, wd);
    wait_ack(k, port);
  endtask

  task automatic wait_mem_read(input int unsigned k);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = mem_read[k];
    end
    chk(k, "mem_read_timeout", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      drive(k, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(k, 1'b1, 1'b0, 1'b0, '0, '0);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int unsigned k = 0; k < 3; k++) begin
      chk(k, "rst_mem_addr", mem_addr[k], 32'd0);
      chk(k, "rst_mem_wdata", mem_write_data[k], 32'd0);
      chk(k, "rst_rdata", rdata[k], 32'd0);
      chk(k, "rst_flags", {26'd0, mem_read[k], mem_write[k], p0_ack[k], p1_ack[k],
                           owner[k], busy[k]}, 32'd0);
    end

    fork
      begin
        // Single read, single write
        push(0, mk(1'b0, 1'b0, 32'h10, 32'h0, 32'hCAFE_BABE));
        do_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
        push(0, mk(1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'hCAFE_BABE));
        do_req(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);

        // Both ports requesting continuously: 0,1,0,1
        push(0, mk(1'b0, 1'b0, 32'h100, 32'h0, 32'hD00D_0100));
        push(0, mk(1'b1, 1'b0, 32'h200, 32'h0, 32'hD00D_0200));
        push(0, mk(1'b0, 1'b0, 32'h104, 32'h0, 32'hD00D_0104));
        push(0, mk(1'b1, 1'b0, 32'h204, 32'h0, 32'hD00D_0204));
        fork
          begin
            do_req(0, 1'b0, 1'b0, 32'h100, 32'h0);
            do_req(0, 1'b0, 1'b0, 32'h104, 32'h0);
          end
          begin
            do_req(0, 1'b1, 1'b0, 32'h200, 32'h0);
            do_req(0, 1'b1, 1'b0, 32'h204, 32'h0);
          end
        join

        // Reset in the second cycle of a read: no ack, state cleared
        drive(0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
        wait_mem_read(0);
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        chk(0, "abort_mem_read", {31'd0, mem_read[0]}, 32'd0);
        chk(0, "abort_busy", {31'd0, busy[0]}, 32'd0);
        chk(0, "abort_rdata", rdata[0], 32'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        #2;
        rst[0] = 1'b0;

        // First tie after reset goes to port 0
        push(0, mk(1'b0, 1'b0, 32'h50, 32'h0, 32'hD00D_0050));
        push(0, mk(1'b1, 1'b0, 32'h60, 32'h0, 32'hD00D_0060));
        fork
          do_req(0, 1'b0, 1'b0, 32'h50, 32'h0);
          do_req(0, 1'b1, 1'b0, 32'h60, 32'h0);
        join

        // Address changed after grant is ignored; p0 re-granted with p1 idle
        push(0, mk(1'b0, 1'b0, 32'h40, 32'h0, 32'hD00D_0040));
        drive(0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        wait_mem_read(0);
        p0_addr[0] = 32'h44;
        wait_ack(0, 1'b0);
        push(0, mk(1'b0, 1'b0, 32'h44, 32'h0, 32'hD00D_0044));
        do_req(0, 1'b0, 1'b0, 32'h44, 32'h0);
      end
      begin
        // Latency sweep instances
        for (int unsigned k = 1; k < 3; k++) begin
          push(k, mk(1'b0, 1'b0, 32'h10, 32'h0, 32'hCAFE_BABE));
          do_req(k, 1'b0, 1'b0, 32'h10, 32'h0);
          push(k, mk(1'b1, 1'b1, 32'h20, 32'hA5A5_0000 | k, 32'hCAFE_BABE));
          do_req(k, 1'b1, 1'b1, 32'h20, 32'hA5A5_0000 | k);
        end
      end
    join

    repeat (4) @(negedge clk);
    chk(0, "sb_empty", g_inst[0].sb.size(), 32'd0);
    chk(1, "sb_empty", g_inst[1].sb.size(), 32'd0);
    chk(2, "sb_empty", g_inst[2].sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single fixed-latency memory port (mem_addr / mem_read / mem_write / mem_write_data / mem_read_data) between two requesters: port 0 (CPU controller) and port 1 (DMA or debug engine).
- Sequences each access with the same timing the memory expects: read data is captured READ_LAT edges after the address is registered, and mem_write is held for WRITE_LAT cycles.
- Sits between the processor controller and the memory model. Arbitration between the two ports is round-robin.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- READ_LAT, 3, edges from mem_read assertion to mem_read_data capture; legal range 1..15.
- WRITE_LAT, 1, cycles mem_write is held high; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 request; held with p0_we/p0_addr/p0_wdata stable until p0_ack.
- p0_we  in  1  port 0: 1=write, 0=read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  port 0 completion, one-cycle pulse.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack  same as the port 0 signals, for port 1.
- rdata  out  DATA_W  captured read data; valid in the p0_ack/p1_ack cycle of a read.
- owner  out  1  port currently or last granted.
- busy  out  1  high in states READ, WRITE and ACK.
- mem_addr  out  ADDR_W  registered memory address.
- mem_write_data  out  DATA_W  registered write data.
- mem_read  out  1  registered read enable.
- mem_write  out  1  registered write enable.
- mem_read_data  in  DATA_W  memory read data.

Behaviour:
- Reset (asynchronous; takes effect immediately, including mid-access):
  - state=IDLE; mem_read=mem_write=0; p0_ack=p1_ack=0.
  - mem_addr=0, mem_write_data=0, rdata=0, cnt=0.
  - last=1 (so port 0 wins first); owner=0.
  - An aborted access produces no ack.
- State machine: IDLE, READ, WRITE, ACK. Every output is registered.
- IDLE: arbitration is sampled at the rising edge.
  - Only one req high: that port is granted.
  - Both high: grant the port != last.
  - On grant:
    - owner<=g, last<=g.
    - mem_addr<=pg_addr.
    - cnt<=LAT-1, where LAT is READ_LAT or WRITE_LAT.
    - pg_we=0: mem_read<=1, go to READ.
    - pg_we=1: mem_write<=1, mem_write_data<=pg_wdata, go to WRITE.
  - No request: stay in IDLE with no output change.
- READ:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: rdata<=mem_read_data, mem_read<=0, pg_ack<=1, go to ACK.
- WRITE:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: mem_write<=0, pg_ack<=1, go to ACK. rdata is unchanged.
- ACK:
  - Ack pulse is visible for exactly one cycle; ack<=0 at the end of it, go to IDLE.
  - No arbitration in ACK. This lets a requester drop req at the edge ending ACK without being granted twice.
- Latency, with G = IDLE edge that grants:
  - Read: mem_read high for cycles G..G+READ_LAT; capture at edge G+READ_LAT; ack in the following cycle.
  - Write: mem_write high for WRITE_LAT cycles.
  - Minimum gap between consecutive grants: one IDLE cycle.
- Request inputs are ignored outside IDLE. Changing addr, we or wdata after grant has no effect.
- Never assert mem_read and mem_write together. Never assert both acks.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1.
- Back-to-back requests from one port with the other idle: the same port is granted again.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding: IDLE=0, READ=1, WRITE=2, ACK=3;
  - CNT_W=4;
  - defaults for READ_LAT and WRITE_LAT.
- One sub-module, mem_arb_rr: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt_valid, gnt_id.
- The FSM, counter and datapath registers stay in mem_port_arbiter.

Test Plan:
- Reset, then p0 read of addr 0x10 with memory returning 0xCAFEBABE → mem_read high for exactly 3 cycles, mem_addr=0x10, p0_ack one cycle, rdata=0xCAFEBABE, p1_ack stays 0.
- p1 write of addr 0x20 with data 0x12345678 → mem_write high exactly 1 cycle, mem_write_data=0x12345678, then p1_ack; rdata unchanged.
- p0 and p1 both requesting reads continuously for 4 grants → owner sequence 0,1,0,1; each ack is followed by one IDLE cycle; no overlap of mem_read/mem_write.
- Reset pulsed during cycle 2 of a read → mem_read drops immediately; no ack; next p1 request is served normally, with port 0 winning the first tie after reset.
- Parameter sweep READ_LAT=1 and 15, WRITE_LAT=4 → capture edge and mem_write width match the parameter exactly.
- p0 changes addr from 0x40 to 0x44 after grant → memory still sees 0x40; a second p0 request with p1 idle is granted to p0 again.
